// File: rtl/alu_cond_stage.sv
// alu_cond_stage
//   EX/MEM stage sitting right behind the ALU. Holds the NZV status register,
//   evaluates 4-bit ARM-style condition codes against it, and registers the
//   pipeline word with register/memory writes gated by the condition result.
//   Also counts instructions that were annulled by a failed condition.
//
// Ports
//   clk, rst_n                   clock (rising edge), async active-low reset
//   in_valid                     ALU slot holds a real instruction
//   alu_result, alu_z/n/v        ALU result and flags
//   cond, set_flags              condition code, S bit
//   in_rd, in_reg_write,
//   in_mem_write                 destination and write enables
//   stall, flush                 hazard-unit controls (flush wins)
//   out_valid, out_result,
//   out_rd, out_reg_write,
//   out_mem_write                registered EX/MEM word
//   flags_nzv                    status register {N,Z,V}
//   cond_pass                    combinational condition result
//   annul_count                  count of condition-failed instructions
module alu_cond_stage #(
    parameter int N  = 32,
    parameter int RW = 4,
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    input  logic [N-1:0]  alu_result,
    input  logic          alu_z,
    input  logic          alu_n,
    input  logic          alu_v,
    input  logic [3:0]    cond,
    input  logic          set_flags,
    input  logic [RW-1:0] in_rd,
    input  logic          in_reg_write,
    input  logic          in_mem_write,
    input  logic          stall,
    input  logic          flush,
    output logic          out_valid,
    output logic [N-1:0]  out_result,
    output logic [RW-1:0] out_rd,
    output logic          out_reg_write,
    output logic          out_mem_write,
    output logic [2:0]    flags_nzv,
    output logic          cond_pass,
    output logic [CW-1:0] annul_count
);

    logic f_n, f_z, f_v;
    logic accept, live, slot_ok;

    assign {f_n, f_z, f_v} = flags_nzv;

    // Conditions look only at the registered flags; carry-based codes
    // (no carry from the ALU) and the reserved 1111 never pass.
    always_comb begin
        cond_pass = 1'b0;
        case (cond)
            4'b0000: cond_pass = f_z;
            4'b0001: cond_pass = !f_z;
            4'b0100: cond_pass = f_n;
            4'b0101: cond_pass = !f_n;
            4'b0110: cond_pass = f_v;
            4'b0111: cond_pass = !f_v;
            4'b1010: cond_pass = (f_n == f_v);
            4'b1011: cond_pass = (f_n != f_v);
            4'b1100: cond_pass = !f_z && (f_n == f_v);
            4'b1101: cond_pass = f_z || (f_n != f_v);
            4'b1110: cond_pass = 1'b1;
            default: cond_pass = 1'b0;
        endcase
    end

    // flush overrides stall: a flushed slot always advances as a bubble
    assign accept  = !stall || flush;
    assign slot_ok = in_valid && !flush;
    assign live    = slot_ok && cond_pass;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid     <= 1'b0;
            out_result    <= '0;
            out_rd        <= '0;
            out_reg_write <= 1'b0;
            out_mem_write <= 1'b0;
            flags_nzv     <= 3'b000;
            annul_count   <= '0;
        end else if (accept) begin
            out_valid     <= slot_ok;
            out_result    <= alu_result;
            out_rd        <= in_rd;
            out_reg_write <= in_reg_write && live;
            out_mem_write <= in_mem_write && live;
            // flags and outputs load on the same edge, so the next
            // instruction already evaluates against this one's flags
            if (live && set_flags)
                flags_nzv <= {alu_n, alu_z, alu_v};
            if (slot_ok && !cond_pass)
                annul_count <= annul_count + CW'(1);
        end
    end

endmodule
